// File: rtl/fsm_controller_pkg.sv
// router_pkg: shared state encoding, address constants and FIFO select helper
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR0        = 2'd0;
    localparam logic [1:0] ADDR1        = 2'd1;
    localparam logic [1:0] ADDR2        = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    // Picks the per-FIFO flag for an address; the invalid address selects nothing
    function automatic logic sel3(input logic [2:0] v, input logic [1:0] a);
        return (a == ADDR0) ? v[0] :
               (a == ADDR1) ? v[1] :
               (a == ADDR2) ? v[2] : 1'b0;
    endfunction

endpackage

// File: rtl/fsm_controller_if.sv
// fsm_controller_if: handshake between router datapath/FIFOs and the control FSM
interface fsm_controller_if;
    logic       pkt_valid;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_rst_0;
    logic       soft_rst_1;
    logic       soft_rst_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [1:0] din;
    logic       wr_en_req;
    logic       detect_addr;
    logic       lfd_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_req;
    logic       busy;

    modport master (
        output pkt_valid, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_rst_0, soft_rst_1, soft_rst_2, parity_done, low_pkt_valid, din,
        input  wr_en_req, detect_addr, lfd_state, laf_state, full_state, rst_int_req, busy
    );

    modport slave (
        input  pkt_valid, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_rst_0, soft_rst_1, soft_rst_2, parity_done, low_pkt_valid, din,
        output wr_en_req, detect_addr, lfd_state, laf_state, full_state, rst_int_req, busy
    );
endinterface

// File: rtl/fsm_controller.sv
// fsm_controller: packet router control FSM sequencing header/payload/parity writes
module fsm_controller
    import router_pkg::*;
(
    input logic             clk,
    input logic             rst,
    fsm_controller_if.slave bus
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_addr;
    logic [2:0] w_empty;
    logic       w_empty_din;
    logic       w_empty_addr;
    logic       w_soft_rst;

    assign w_empty      = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign w_empty_din  = sel3(w_empty, bus.din);
    assign w_empty_addr = sel3(w_empty, r_addr);
    assign w_soft_rst   = sel3({bus.soft_rst_2, bus.soft_rst_1, bus.soft_rst_0}, r_addr);

    // State register and destination latch captured while decoding a valid header
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= ADDR0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE_ADDRESS && bus.pkt_valid && bus.din != ADDR_INVALID)
                r_addr <= bus.din;
        end
    end

    // Next state; a soft reset of the addressed FIFO aborts any packet in flight
    always_comb begin
        w_next = r_state;
        case (r_state)
            DECODE_ADDRESS:
                if (bus.pkt_valid && bus.din != ADDR_INVALID)
                    w_next = w_empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:    w_next = LOAD_DATA;
            LOAD_DATA:          w_next = bus.fifo_full ? FIFO_FULL_STATE :
                                         !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
            LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: w_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE:    w_next = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:    w_next = bus.parity_done ? DECODE_ADDRESS :
                                         bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
            WAIT_TILL_EMPTY:    w_next = w_empty_addr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            default:            w_next = DECODE_ADDRESS;
        endcase
        if (r_state != DECODE_ADDRESS && w_soft_rst)
            w_next = DECODE_ADDRESS;
    end

    // Moore output decode straight from the state register
    always_comb begin
        bus.detect_addr = r_state == DECODE_ADDRESS;
        bus.lfd_state   = r_state == LOAD_FIRST_DATA;
        bus.laf_state   = r_state == LOAD_AFTER_FULL;
        bus.full_state  = r_state == FIFO_FULL_STATE;
        bus.rst_int_req = r_state == CHECK_PARITY_ERROR;
        bus.wr_en_req   = r_state == LOAD_DATA || r_state == LOAD_PARITY ||
                          r_state == LOAD_AFTER_FULL;
        bus.busy        = !(r_state == DECODE_ADDRESS || r_state == LOAD_DATA);
    end

endmodule

// File: tb/tb_fsm_controller.sv
// tb_fsm_controller: directed self-checking bench for the router control FSM
module tb_fsm_controller;

    // Output vector order: {wr_en_req, detect_addr, lfd, laf, full, rst_int_req, busy}
    localparam logic [6:0] E_DEC  = 7'b0100000;
    localparam logic [6:0] E_LFD  = 7'b0010001;
    localparam logic [6:0] E_LD   = 7'b1000000;
    localparam logic [6:0] E_LP   = 7'b1000001;
    localparam logic [6:0] E_FULL = 7'b0000101;
    localparam logic [6:0] E_LAF  = 7'b1001001;
    localparam logic [6:0] E_WAIT = 7'b0000001;
    localparam logic [6:0] E_CPE  = 7'b0000011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fsm_controller_if bus ();

    fsm_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {bus.wr_en_req, bus.detect_addr, bus.lfd_state, bus.laf_state,
               bus.full_state, bus.rst_int_req, bus.busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        bus.pkt_valid = 0; bus.fifo_full = 0; bus.din = 2'd0;
        bus.fifo_empty_0 = 1; bus.fifo_empty_1 = 1; bus.fifo_empty_2 = 1;
        bus.soft_rst_0 = 0; bus.soft_rst_1 = 0; bus.soft_rst_2 = 0;
        bus.parity_done = 0; bus.low_pkt_valid = 0;
        tick(); tick();
        chk("reset", E_DEC);
        rst = 1;
        tick();
        chk("idle", E_DEC);

        bus.pkt_valid = 1; bus.din = 2'd0;
        tick(); chk("t1_lfd", E_LFD);
        tick(); chk("t1_ld", E_LD);
        tick(); chk("t1_ld_hold", E_LD);
        bus.pkt_valid = 0;
        tick(); chk("t1_lp", E_LP);
        tick(); chk("t1_cpe", E_CPE);
        tick(); chk("t1_dec", E_DEC);

        bus.pkt_valid = 1; bus.din = 2'd1; bus.fifo_empty_1 = 0;
        tick(); chk("t2_wait", E_WAIT);
        bus.din = 2'd0;
        tick(); chk("t2_wait_ign_din", E_WAIT);
        tick(); chk("t2_wait2", E_WAIT);
        bus.fifo_empty_1 = 1;
        tick(); chk("t2_lfd", E_LFD);
        tick(); chk("t2_ld", E_LD);

        bus.fifo_full = 1;
        tick(); chk("t3_full", E_FULL);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t3_full_hold", E_FULL);
        end
        bus.fifo_full = 0;
        tick(); chk("t3_laf", E_LAF);
        tick(); chk("t3_ld", E_LD);

        bus.fifo_full = 1;
        tick(); chk("t4_full", E_FULL);
        bus.fifo_full = 0;
        tick(); chk("t4_laf", E_LAF);
        bus.low_pkt_valid = 1;
        tick(); chk("t4_lp_lowpv", E_LP);
        bus.low_pkt_valid = 0; bus.pkt_valid = 0;
        tick(); chk("t4_cpe", E_CPE);
        tick(); chk("t4_dec", E_DEC);

        bus.pkt_valid = 1; bus.din = 2'd1;
        tick(); chk("t4b_lfd", E_LFD);
        tick(); chk("t4b_ld", E_LD);
        bus.fifo_full = 1;
        tick(); chk("t4b_full", E_FULL);
        bus.fifo_full = 0;
        tick(); chk("t4b_laf", E_LAF);
        bus.parity_done = 1; bus.pkt_valid = 0;
        tick(); chk("t4b_dec_pdone", E_DEC);
        bus.parity_done = 0;

        bus.pkt_valid = 1; bus.din = 2'd0;
        tick(); chk("t4c_lfd", E_LFD);
        tick(); chk("t4c_ld", E_LD);
        bus.pkt_valid = 0;
        tick(); chk("t4c_lp", E_LP);
        bus.fifo_full = 1;
        tick(); chk("t4c_cpe", E_CPE);
        tick(); chk("t4c_cpe_full", E_FULL);
        bus.fifo_full = 0; bus.parity_done = 1;
        tick(); chk("t4c_laf", E_LAF);
        tick(); chk("t4c_dec", E_DEC);
        bus.parity_done = 0;

        bus.pkt_valid = 1; bus.din = 2'd2; bus.fifo_empty_2 = 0;
        tick(); chk("t5_wait", E_WAIT);
        bus.pkt_valid = 0; bus.soft_rst_0 = 1;
        tick(); chk("t5_srst_other", E_WAIT);
        bus.soft_rst_0 = 0; bus.soft_rst_2 = 1;
        tick(); chk("t5_srst_own", E_DEC);
        bus.pkt_valid = 1; bus.fifo_empty_2 = 1;
        tick(); chk("t5_srst_ign_dec", E_LFD);
        tick(); chk("t5_srst_lfd", E_DEC);
        bus.soft_rst_2 = 0; bus.pkt_valid = 0;

        bus.pkt_valid = 1; bus.din = 2'd3;
        tick(); chk("t6_invalid", E_DEC);
        tick(); chk("t6_invalid2", E_DEC);
        bus.din = 2'd0;
        tick(); chk("t6_lfd", E_LFD);
        tick(); chk("t6_ld", E_LD);
        #2 rst = 0;
        #1 chk("t6_async_rst", E_DEC);
        rst = 1; bus.pkt_valid = 0;
        tick(); chk("t6_after_rst", E_DEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_controller.md
Name: fsm_controller

Overview:
Control FSM for a 1-input / 3-output packet router. It decodes the 2-bit destination address from the packet header and sequences header, payload and parity writes into one of three output FIFOs. It also handles FIFO-full stalls, per-FIFO soft resets and the parity-check hand-off. It sits between the input register/synchroniser logic and the three output FIFOs.

Parameters:
none (state encoding and address values are fixed constants in the shared package)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
pkt_valid  input  1  packet in progress; deasserts on the parity byte
fifo_full  input  1  full flag of the currently addressed FIFO
fifo_empty_0  input  1  FIFO 0 empty
fifo_empty_1  input  1  FIFO 1 empty
fifo_empty_2  input  1  FIFO 2 empty
soft_rst_0  input  1  soft reset (read timeout) of FIFO 0
soft_rst_1  input  1  soft reset of FIFO 1
soft_rst_2  input  1  soft reset of FIFO 2
parity_done  input  1  parity byte already captured by the register block
low_pkt_valid  input  1  pkt_valid dropped while in a full stall
din  input  2  header address field (0, 1, 2 valid; 3 invalid)
wr_en_req  output  1  write-enable request to the FIFOs
detect_addr  output  1  FSM is in DECODE_ADDRESS
lfd_state  output  1  FSM is in LOAD_FIRST_DATA (header write)
laf_state  output  1  FSM is in LOAD_AFTER_FULL
full_state  output  1  FSM is in FIFO_FULL_STATE
rst_int_req  output  1  request to reset the internal parity/low_pkt_valid logic
busy  output  1  router cannot accept a new input byte

Behaviour:
- Reset: rst=0 forces state to DECODE_ADDRESS asynchronously and clears the latched address to 0.
- Reset output values: detect_addr=1; all other outputs 0.
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
- Address latch: in DECODE_ADDRESS with pkt_valid=1 and din!=3, din is latched into a 2-bit addr register.
- DECODE_ADDRESS:
  - pkt_valid=1, din=k (k in 0..2) and fifo_empty_k=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, din=k and fifo_empty_k=0 -> WAIT_TILL_EMPTY.
  - Otherwise (including din=3) stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA:
  - fifo_full=1 -> FIFO_FULL_STATE (fifo_full has priority).
  - else pkt_valid=0 -> LOAD_PARITY.
  - else stay.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS.
  - else low_pkt_valid=1 -> LOAD_PARITY.
  - else -> LOAD_DATA.
- WAIT_TILL_EMPTY: fifo_empty_addr=1 -> LOAD_FIRST_DATA; else stay. Uses the latched addr; din is ignored here.
- Soft reset:
  - Applies in any state except DECODE_ADDRESS.
  - If soft_rst_k=1 and latched addr==k, next state is DECODE_ADDRESS; this overrides every other transition.
  - Soft resets of non-addressed FIFOs are ignored.
- Outputs are Moore, decoded combinationally from state:
  - detect_addr = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - laf_state = LOAD_AFTER_FULL
  - full_state = FIFO_FULL_STATE
  - rst_int_req = CHECK_PARITY_ERROR
  - wr_en_req = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA
- Latency: one clock per transition; outputs change with state and need no extra register stage.

Decomposition:
- Package router_pkg holds:
  - the 3-bit state enum (8 named states);
  - address constants ADDR0=0, ADDR1=1, ADDR2=2, ADDR_INVALID=3.
- Single module; no sub-modules needed.
- Structure: one state register, one addr register, one next-state combinational block and one output decode block.

Test Plan:
1. Reset then normal packet:
   - Stimulus: rst 0->1; pkt_valid=1, din=0, fifo_empty_0=1.
   - Response: edge 1 -> LOAD_FIRST_DATA (lfd_state=1, busy=1); edge 2 -> LOAD_DATA (wr_en_req=1, busy=0).
   - Then pkt_valid=0: next edges LOAD_PARITY (wr_en_req=1, busy=1) -> CHECK_PARITY_ERROR (rst_int_req=1) -> DECODE_ADDRESS (detect_addr=1).
2. Busy destination:
   - Stimulus: din=1, fifo_empty_1=0, pkt_valid=1.
   - Response: WAIT_TILL_EMPTY with busy=1, wr_en_req=0; stays until fifo_empty_1=1, then LOAD_FIRST_DATA.
3. Full stall, payload not yet finished:
   - Stimulus: in LOAD_DATA set fifo_full=1.
   - Response: FIFO_FULL_STATE (full_state=1, busy=1); hold fifo_full=1 for 3 cycles and the state stays.
   - Then fifo_full=0, parity_done=0, low_pkt_valid=0: LOAD_AFTER_FULL (laf_state=1, wr_en_req=1) -> LOAD_DATA.
4. Full stall variants:
   - From LOAD_AFTER_FULL with low_pkt_valid=1, parity_done=0 -> LOAD_PARITY.
   - From LOAD_AFTER_FULL with parity_done=1 -> DECODE_ADDRESS.
5. Soft reset:
   - Stimulus: in WAIT_TILL_EMPTY with addr=2, pulse soft_rst_0.
   - Response: no change.
   - Then pulse soft_rst_2: next edge DECODE_ADDRESS, detect_addr=1.
6. Invalid address and async reset:
   - din=3, pkt_valid=1 -> FSM stays in DECODE_ADDRESS.
   - rst=0 asserted mid-LOAD_DATA -> DECODE_ADDRESS immediately, without waiting for a clock edge.
